branch_target_pipe: RTL and testbench

Two-stage pipelined, parametrised immediate-offset unit for the branch/jump path. It sign-extends either a short or a long immediate field, selected per transaction, and left-shifts it by a fixed amount. It then adds the result to a base address (PC) and reports representability and wrap conditions. It sits between decode and the PC-update logic, with valid/ready flow control on both sides.

---
 rtl/branch_target_pipe.sv | 100 ++++++++++
 tb/tb_branch_target_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/branch_target_pipe.sv
// Two-stage branch/jump target unit: sign-extend a short or long immediate, shift it,
// add it to a base address, and flag shift loss and address wrap. Valid/ready on both sides.
module branch_target_pipe #(
    parameter int DATA_WIDTH    = 16,
    parameter int IMM_MAX_WIDTH = 12,
    parameter int IMM_MIN_WIDTH = 8,
    parameter int SHIFT_AMOUNT  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IMM_MAX_WIDTH-1:0] imm_in,
    input  logic                     width_sel,
    input  logic [DATA_WIDTH-1:0]    base_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    offset_out,
    output logic [DATA_WIDTH-1:0]    target_out,
    output logic                     shift_loss_out,
    output logic                     wrap_out
);

    logic signed [IMM_MAX_WIDTH-1:0] imm_long;
    logic signed [IMM_MIN_WIDTH-1:0] imm_short;
    logic signed [DATA_WIDTH-1:0]    ext;
    logic signed [DATA_WIDTH-1:0]    ext_top;
    logic [DATA_WIDTH-1:0]           off_next;
    logic                            loss_next;

    logic                  s1_v;
    logic [DATA_WIDTH-1:0] s1_off;
    logic [DATA_WIDTH-1:0] s1_base;
    logic                  s1_loss;
    logic                  s2_v;

    logic                  s2_adv;
    logic                  s1_adv;
    logic                  in_fire;
    logic [DATA_WIDTH+1:0] sum;

    assign imm_long  = imm_in;
    assign imm_short = imm_in[IMM_MIN_WIDTH-1:0];

    // Stage 1 datapath: extension, shift and the representability check.
    // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
    always_comb begin
        ext = '0;
        if (width_sel) ext = DATA_WIDTH'(imm_long);
        else           ext = DATA_WIDTH'(imm_short);
        off_next = ext << SHIFT_AMOUNT;
        // The shift is lossless only if the top SHIFT_AMOUNT+1 bits are copies of the sign.
        ext_top   = ext >>> (DATA_WIDTH - 1 - SHIFT_AMOUNT);
        loss_next = (ext_top != '0) && (ext_top != '1);
    end

    // Two guard bits above the sum expose both overflow (01) and underflow (11).
    assign sum = {2'b00, s1_base} + {{2{s1_off[DATA_WIDTH-1]}}, s1_off};

    assign s2_adv    = !s2_v || out_ready;
    assign s1_adv    = s1_v && s2_adv;
    assign in_ready  = !rst && (!s1_v || s2_adv);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_v;

    // NOTE: sequential state uses non-blocking '<=' so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v           <= 1'b0;
            s1_off         <= '0;
            s1_base        <= '0;
            s1_loss        <= 1'b0;
            s2_v           <= 1'b0;
            offset_out     <= '0;
            target_out     <= '0;
            shift_loss_out <= 1'b0;
            wrap_out       <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_v    <= 1'b1;
                s1_off  <= off_next;
                s1_base <= base_in;
                s1_loss <= loss_next;
            end else if (s1_adv) begin
                s1_v <= 1'b0;
            end

            if (s1_adv) begin
                s2_v           <= 1'b1;
                offset_out     <= s1_off;
                target_out     <= sum[DATA_WIDTH-1:0];
                shift_loss_out <= s1_loss;
                wrap_out       <= (sum[DATA_WIDTH+1:DATA_WIDTH] != 2'b00);
            end else if (s2_v && out_ready) begin
                s2_v <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_pipe.sv
// Directed bench for branch_target_pipe: default instance plus a SHIFT_AMOUNT=5 instance
// sharing the same stimulus; expected values are hand-computed constants.
module tb_branch_target_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] imm_in;
    logic        width_sel;
    logic [15:0] base_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] offset_out;
    logic [15:0] target_out;
    logic        shift_loss_out;
    logic        wrap_out;

    logic        in_ready5;
    logic        out_valid5;
    logic [15:0] offset_out5;
    logic [15:0] target_out5;
    logic        shift_loss_out5;
    logic        wrap_out5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_target_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .imm_in(imm_in), .width_sel(width_sel), .base_in(base_in),
        .out_valid(out_valid), .out_ready(out_ready), .offset_out(offset_out),
        .target_out(target_out), .shift_loss_out(shift_loss_out), .wrap_out(wrap_out)
    );

    branch_target_pipe #(.SHIFT_AMOUNT(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready5),
        .imm_in(imm_in), .width_sel(width_sel), .base_in(base_in),
        .out_valid(out_valid5), .out_ready(out_ready), .offset_out(offset_out5),
        .target_out(target_out5), .shift_loss_out(shift_loss_out5), .wrap_out(wrap_out5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [15:0] off, input logic [15:0] tgt,
                             input logic loss, input logic wrap);
        check({tag, "_off"},  offset_out,     off);
        check({tag, "_tgt"},  target_out,     tgt);
        check({tag, "_loss"}, shift_loss_out, loss);
        check({tag, "_wrap"}, wrap_out,       wrap);
    endtask

    // One transaction with out_ready high; result is on the outputs when this returns.
    task automatic run_one(input string tag, input logic ws, input logic [11:0] imm,
                           input logic [15:0] base);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        width_sel = ws;
        imm_in    = imm;
        base_in   = base;
        #1;
        check({tag, "_rdy"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        imm_in   = '0;
        base_in  = '0;
        check({tag, "_v1"}, out_valid, 0);
        step();
        check({tag, "_v2"}, out_valid, 1);
    endtask

    task automatic push(input logic ws, input logic [11:0] imm, input logic [15:0] base);
        in_valid  = 1'b1;
        width_sel = ws;
        imm_in    = imm;
        base_in   = base;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        imm_in    = '0;
        width_sel = 1'b0;
        base_in   = '0;
        out_ready = 1'b0;

        // Reset state
        step();
        step();
        check("rst_rdy", in_ready, 0);
        check("rst_vld", out_valid, 0);
        check_out("rst", 16'h0000, 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_rdy", in_ready, 1);

        // Short field, negative
        run_one("short_neg", 1'b0, 12'h0FF, 16'h0100);
        check_out("short_neg", 16'hFFFE, 16'h00FE, 1'b0, 1'b0);

        // Long field, underflow
        run_one("long_uf", 1'b1, 12'h800, 16'h0010);
        check_out("long_uf", 16'hF000, 16'hF010, 1'b0, 1'b1);

        // Long field, overflow; shift-5 instance loses bits on the same input
        run_one("long_of", 1'b1, 12'h7FF, 16'hFFFE);
        check_out("long_of", 16'h0FFE, 16'h0FFC, 1'b0, 1'b1);
        check("sh5_loss_off",  offset_out5,     16'hFFE0);
        check("sh5_loss_flag", shift_loss_out5, 1);

        run_one("sh5_ok", 1'b1, 12'h03F, 16'h0000);
        check("sh5_ok_off",  offset_out5,     16'h07E0);
        check("sh5_ok_flag", shift_loss_out5, 0);
        check_out("sh1_ok", 16'h007E, 16'h007E, 1'b0, 1'b0);

        // Upper imm bits ignored for the short field
        run_one("ignore_hi", 1'b0, 12'hA7F, 16'h0000);
        check_out("ignore_hi", 16'h00FE, 16'h00FE, 1'b0, 1'b0);
        step();
        check("drain_vld", out_valid, 0);

        // Backpressure: A, B accepted; C refused while stalled
        out_ready = 1'b0;
        push(1'b0, 12'h001, 16'h1000);
        #1;
        check("bp_rdy_a", in_ready, 1);
        step();
        push(1'b0, 12'h080, 16'h1000);
        #1;
        check("bp_rdy_b", in_ready, 1);
        step();
        push(1'b1, 12'h100, 16'h2000);
        #1;
        check("bp_rdy_c", in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("bp_stall%0d_rdy", i), in_ready, 0);
            check($sformatf("bp_stall%0d_vld", i), out_valid, 1);
            check_out($sformatf("bp_stall%0d", i), 16'h0002, 16'h1002, 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_rdy_release", in_ready, 1);
        check_out("bp_a", 16'h0002, 16'h1002, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        check("bp_b_vld", out_valid, 1);
        check_out("bp_b", 16'hFF00, 16'h0F00, 1'b0, 1'b0);
        step();
        check("bp_c_vld", out_valid, 1);
        check_out("bp_c", 16'h0200, 16'h2200, 1'b0, 1'b0);
        step();
        check("bp_done_vld", out_valid, 0);
        check_out("bp_hold", 16'h0200, 16'h2200, 1'b0, 1'b0);

        // Reset mid-stream with both stages full
        out_ready = 1'b0;
        push(1'b1, 12'h800, 16'h0010);
        step();
        push(1'b1, 12'h7FF, 16'hFFFE);
        step();
        in_valid = 1'b0;
        check("mid_full_vld", out_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_rdy", in_ready, 0);
        step();
        rst = 1'b0;
        #1;
        check("mid_vld", out_valid, 0);
        check_out("mid", 16'h0000, 16'h0000, 1'b0, 1'b0);
        check("mid_rdy", in_ready, 1);
        run_one("post_mid", 1'b0, 12'h0FF, 16'h0100);
        check_out("post_mid", 16'hFFFE, 16'h00FE, 1'b0, 1'b0);
        step();
        check("post_mid_drain", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
